// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants for the 3-digit display scanner: active-low segment glyphs,
// digit-slot state encodings and the captured BCD value record.
package bcd_display_scanner_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [1:0] S_ONES = 2'd0;
    localparam logic [1:0] S_TENS = 2'd1;
    localparam logic [1:0] S_HUND = 2'd2;

    typedef struct packed {
        logic [1:0] hund;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_value_t;

endpackage

// File: rtl/bcd_display_scanner_to_7seg.sv
// Combinational 4-bit code to active-low 7-segment glyph; codes 10-15 show a dash.
module bcd_to_7seg
    import bcd_display_scanner_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed 3-digit common-anode driver with tear-free frame latching,
// inter-digit blanking gap and optional leading-zero suppression.
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GAP      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [1:0] hundreds,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame
);

    localparam int             CW    = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  GAP_C = CW'(GAP);

    logic [CW-1:0] count, count_next;
    logic [1:0]    state, state_next;
    bcd_value_t    pending, pending_next;
    bcd_value_t    display, display_next;
    logic          wrap, boundary;
    logic [3:0]    code;
    logic          blanked;
    logic [2:0]    an_sel, an_next;
    logic [6:0]    glyph, seg_next;

    // Outputs are registered from next-state values so SEG/AN line up with
    // the slot counter they belong to, with no input-to-output comb path.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_next = state;
        wrap       = (count == LAST);
        count_next = wrap ? '0 : count + 1'b1;
        if (wrap) begin
            case (state)
                S_ONES:  state_next = S_TENS;
                S_TENS:  state_next = S_HUND;
                default: state_next = S_ONES;
            endcase
        end
        boundary     = wrap && (state == S_HUND);
        pending_next = load ? '{hund: hundreds, tens: tens, ones: ones} : pending;
        // A LOAD on the boundary edge lands in display straight away.
        display_next = boundary ? pending_next : display;
    end

    always_comb begin
        code    = display_next.ones;
        blanked = 1'b0;
        an_sel  = 3'b110;
        case (state_next)
            S_TENS: begin
                code    = display_next.tens;
                blanked = blank_lz && (display_next.hund == 2'd0) && (display_next.tens == 4'd0);
                an_sel  = 3'b101;
            end
            S_HUND: begin
                code    = {2'b00, display_next.hund};
                blanked = blank_lz && (display_next.hund == 2'd0);
                an_sel  = 3'b011;
            end
            default: ;
        endcase
        seg_next = blanked ? SEG_OFF : glyph;
        an_next  = (blanked || (count_next < GAP_C)) ? 3'b111 : an_sel;
    end

    bcd_to_7seg u_decode (
        .code (code),
        .seg  (glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            state   <= S_ONES;
            pending <= '0;
            display <= '0;
            seg     <= SEG_OFF;
            an      <= 3'b111;
            frame   <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            count   <= count_next;
            state   <= state_next;
            pending <= pending_next;
            display <= display_next;
            seg     <= seg_next;
            an      <= an_next;
            frame   <= boundary;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner at SCAN_DIV=8, GAP=2 (24-cycle frame).
module tb_bcd_display_scanner;

    localparam int FRAME_LEN = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ones = '0;
    logic [3:0] tens = '0;
    logic [1:0] hundreds = '0;
    logic       blank_lz = 1'b1;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame;

    int checks = 0;
    int errors = 0;
    int pos = 0;

    typedef struct {
        logic [1:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       blz;
        logic [6:0] seg_o, seg_t, seg_h;
        logic [2:0] an_o, an_t, an_h;
    } vec_t;

    vec_t vecs[8];

    bcd_display_scanner #(.SCAN_DIV(8), .GAP(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .ones     (ones),
        .tens     (tens),
        .hundreds (hundreds),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (pos %0d): got %h expected %h", name, pos, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        pos = (pos + 1) % FRAME_LEN;
        @(negedge clk);
    endtask

    task automatic goto_pos(input int p);
        for (int i = 0; i < FRAME_LEN && pos != p; i++) tick();
    endtask

    task automatic do_load(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o);
        hundreds = h;
        tens     = t;
        ones     = o;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd2, 4'd5,  4'd5, 1'b1, 7'h12, 7'h12, 7'h24, 3'b110, 3'b101, 3'b011};
        vecs[1] = '{2'd2, 4'd0,  4'd0, 1'b1, 7'h40, 7'h40, 7'h24, 3'b110, 3'b101, 3'b011};
        vecs[2] = '{2'd0, 4'd0,  4'd5, 1'b1, 7'h12, 7'h7F, 7'h7F, 3'b110, 3'b111, 3'b111};
        vecs[3] = '{2'd0, 4'd0,  4'd5, 1'b0, 7'h12, 7'h40, 7'h40, 3'b110, 3'b101, 3'b011};
        vecs[4] = '{2'd0, 4'd0,  4'hC, 1'b0, 7'h3F, 7'h40, 7'h40, 3'b110, 3'b101, 3'b011};
        vecs[5] = '{2'd3, 4'd0,  4'd9, 1'b1, 7'h10, 7'h40, 7'h30, 3'b110, 3'b101, 3'b011};
        vecs[6] = '{2'd0, 4'd1,  4'd0, 1'b1, 7'h40, 7'h79, 7'h7F, 3'b110, 3'b101, 3'b111};
        vecs[7] = '{2'd1, 4'hA,  4'd8, 1'b0, 7'h00, 7'h3F, 7'h79, 3'b110, 3'b101, 3'b011};

        // Reset held, then release and walk the whole first frame.
        repeat (3) @(negedge clk);
        check("reset_seg", seg, 7'h7F);
        check("reset_an", {4'b0, an}, 7'h07);
        check("reset_frame", {6'b0, frame}, 7'h00);
        rst_n = 1'b1;
        pos   = 0;
        for (int k = 1; k <= FRAME_LEN; k++) begin
            tick();
            check("idle_frame", {6'b0, frame}, (k == FRAME_LEN) ? 7'h01 : 7'h00);
            check("idle_an", {4'b0, an},
                  ((k < 8) && (k % 8 >= 2)) ? 7'h06 : 7'h07);
            check("idle_seg", seg, ((k < 8) || (k == FRAME_LEN)) ? 7'h40 : 7'h7F);
        end

        // Table: load, wait for the next frame, check each slot in gap and visible phase.
        for (int v = 0; v < 8; v++) begin
            blank_lz = vecs[v].blz;
            do_load(vecs[v].h, vecs[v].t, vecs[v].o);
            goto_pos(0);
            check("vec_frame", {6'b0, frame}, 7'h01);
            check("vec_gap_o_an", {4'b0, an}, 7'h07);
            check("vec_gap_o_seg", seg, vecs[v].seg_o);
            goto_pos(2);
            check("vec_frame_low", {6'b0, frame}, 7'h00);
            check("vec_o_seg", seg, vecs[v].seg_o);
            check("vec_o_an", {4'b0, an}, {4'b0, vecs[v].an_o});
            goto_pos(8);
            check("vec_gap_t_an", {4'b0, an}, 7'h07);
            check("vec_gap_t_seg", seg, vecs[v].seg_t);
            goto_pos(10);
            check("vec_t_seg", seg, vecs[v].seg_t);
            check("vec_t_an", {4'b0, an}, {4'b0, vecs[v].an_t});
            goto_pos(16);
            check("vec_gap_h_an", {4'b0, an}, 7'h07);
            check("vec_gap_h_seg", seg, vecs[v].seg_h);
            goto_pos(18);
            check("vec_h_seg", seg, vecs[v].seg_h);
            check("vec_h_an", {4'b0, an}, {4'b0, vecs[v].an_h});
        end

        // No tearing: a mid-frame LOAD only reaches the display at the next boundary.
        blank_lz = 1'b1;
        goto_pos(0);
        do_load(2'd1, 4'd2, 4'd3);
        goto_pos(0);
        goto_pos(11);
        do_load(2'd2, 4'd0, 4'd0);
        check("tear_t_seg", seg, 7'h24);
        check("tear_t_an", {4'b0, an}, 7'h05);
        goto_pos(18);
        check("tear_h_seg", seg, 7'h79);
        check("tear_h_an", {4'b0, an}, 7'h03);
        goto_pos(0);
        check("tear_frame", {6'b0, frame}, 7'h01);
        goto_pos(2);
        check("new_o_seg", seg, 7'h40);
        check("new_o_an", {4'b0, an}, 7'h06);
        goto_pos(10);
        check("new_t_seg", seg, 7'h40);
        check("new_t_an", {4'b0, an}, 7'h05);
        goto_pos(18);
        check("new_h_seg", seg, 7'h24);
        check("new_h_an", {4'b0, an}, 7'h03);

        // LOAD on the boundary edge shows in the very next ones slot.
        goto_pos(23);
        do_load(2'd0, 4'd0, 4'd7);
        check("bnd_frame", {6'b0, frame}, 7'h01);
        check("bnd_gap_seg", seg, 7'h78);
        check("bnd_gap_an", {4'b0, an}, 7'h07);
        goto_pos(2);
        check("bnd_o_seg", seg, 7'h78);
        check("bnd_o_an", {4'b0, an}, 7'h06);

        // Async reset in the middle of the hundreds slot.
        do_load(2'd2, 4'd5, 4'd5);
        goto_pos(0);
        goto_pos(20);
        check("pre_rst_seg", seg, 7'h24);
        check("pre_rst_an", {4'b0, an}, 7'h03);
        #2 rst_n = 1'b0;
        #1;
        check("arst_seg", seg, 7'h7F);
        check("arst_an", {4'b0, an}, 7'h07);
        check("arst_frame", {6'b0, frame}, 7'h00);
        @(negedge clk);
        blank_lz = 1'b0;
        rst_n    = 1'b1;
        pos      = 0;
        goto_pos(2);
        check("post_rst_o_seg", seg, 7'h40);
        check("post_rst_o_an", {4'b0, an}, 7'h06);
        goto_pos(10);
        check("post_rst_t_seg", seg, 7'h40);
        check("post_rst_t_an", {4'b0, an}, 7'h05);

        // BLANK_LZ change takes effect on the next registered output.
        blank_lz = 1'b1;
        tick();
        check("blz_live_an", {4'b0, an}, 7'h07);
        check("blz_live_seg", seg, 7'h7F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Multiplexed 3-digit 7-segment driver that consumes the ONES/TENS/HUNDREDS outputs of the binary-to-BCD converter. It holds a tear-free copy of the value and scans the digits at a programmable rate, with an inter-digit blanking gap and optional leading-zero suppression. It drives the board's common-anode display directly.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot. 1 kHz per digit at 50 MHz. Must be ≥ GAP+2.
- GAP, 16: cycles at the start of each slot with all anodes off (anti-ghosting). 0 is allowed.
- CLK  input  1  system clock; all state is on the rising edge
- RST_N  input  1  asynchronous, active-low reset
- LOAD  input  1  one-cycle strobe; captures ONES/TENS/HUNDREDS
- ONES  input  4  BCD units digit
- TENS  input  4  BCD tens digit
- HUNDREDS  input  2  hundreds digit, 0–3
- BLANK_LZ  input  1  1 = suppress leading zeros
- SEG  output  7  segment cathodes, active-low; SEG[0]=a … SEG[6]=g
- AN  output  3  digit anodes, active-low; AN[0]=ones, AN[1]=tens, AN[2]=hundreds
- FRAME  output  1  one-cycle pulse at each frame boundary

## Operation
- Registers:
  - pending {H,T,O}: written on every LOAD.
  - display {H,T,O}: copied from pending at each frame boundary.
  - slot counter 0..SCAN_DIV-1.
  - digit state.
- Digit FSM: S_ONES → S_TENS → S_HUND → S_ONES. It advances when the slot counter reaches SCAN_DIV-1; the counter then wraps to 0.
- Frame boundary: the S_HUND→S_ONES transition edge.
  - display ← pending at this edge.
  - FRAME is high for the first cycle of the new S_ONES slot.
- LOAD on the boundary edge: the new inputs go into both pending and display, so the newest value wins and no frame is lost.
- LOAD at any other time: only pending changes. The visible digits never change mid-frame.
- Slot phases:
  - counter < GAP: AN=3'b111; SEG holds the next digit's pattern.
  - otherwise: the selected AN bit is low, unless that digit is blanked.
- Segment decode (a..g lit, active-low on SEG):
  - 0–9: standard glyphs.
  - codes 10–15: dash, g only.
  - HUNDREDS uses the same decode, zero-extended.
- Leading-zero blank (BLANK_LZ=1), evaluated on display:
  - hundreds blanked if H==0.
  - tens blanked if H==0 and T==0.
  - ones never blanked.
  - A blanked digit keeps its AN bit high for the whole slot; SEG=7'h7F.
- BLANK_LZ is sampled every cycle with no latching. A change takes effect from the next registered output.
- Reset (async assert, sync release by system): SEG=7'h7F, AN=3'b111, FRAME=0, state=S_ONES, counter=0, pending=display=0. Reset mid-frame aborts immediately with no partial outputs.

## Timing
- SEG, AN and FRAME are registered and change on the same edge. No combinational path from inputs to outputs.
- LOAD → visible on the display: at most 3·SCAN_DIV cycles. It shows at the first S_ONES slot after the next boundary.
- First cycle after reset release: counter=0 in S_ONES. Ones anode first goes low at cycle GAP (relative to the first clock edge).
- The first FRAME pulse comes 3·SCAN_DIV cycles after reset release; the first frame after reset does not pulse FRAME.
- Frame period: exactly 3·SCAN_DIV cycles. Never stalls.

## Structure
- Shared package/include holds:
  - the segment glyph constants (0–9, DASH, OFF=7'h7F);
  - the state encodings S_ONES/S_TENS/S_HUND.
- One sub-module, `bcd_to_7seg`: combinational 4-bit code to 7-bit active-low segments, instantiated once on the muxed digit.
- Counter width is $clog2(SCAN_DIV).

## Test plan
All tests use SCAN_DIV=8, GAP=2.

- Reset and idle:
  - hold RST_N=0 → SEG=7F, AN=111;
  - release with BLANK_LZ=1 → ones slot shows 0 (SEG=7'h40, AN=110) during counter 2–7;
  - tens and hundreds slots keep AN=111.
- Load 255 (H=2, T=5, O=5) → after the next FRAME:
  - ones slot SEG=7'h12, AN=110;
  - tens slot SEG=7'h12, AN=101;
  - hundreds slot SEG=7'h24, AN=011.
- No tearing:
  - load 123, then load 200 mid-tens-slot → the remainder of the frame still shows 123;
  - the next frame shows 200. With BLANK_LZ=1, the zeros in 200 are not blanked.
- Boundary LOAD: LOAD=7 on the boundary edge → the ones slot immediately following that edge shows 7 (SEG=7'h78).
- Leading-zero and invalid codes:
  - value 005, BLANK_LZ=1 → only AN[0] ever goes low;
  - BLANK_LZ=0 → all three digits show, 0 0 5;
  - ONES=4'hC → SEG=7'h3F (dash).
- Async reset mid-slot: assert RST_N low between edges in the hundreds slot → SEG=7F, AN=111 immediately; after release, the scan restarts at S_ONES with the display value 0.
